// File: rtl/pfb_pkg.sv
// pfb_pkg: shared types and defaults for the polyphase filter bank back end
package pfb_pkg;
  localparam int PFB_WIDTH = 16;
  localparam int PFB_FFT_LEN = 32;
  localparam int PFB_DEC_FAC = 24;
  localparam int ADDR_W = $clog2(PFB_FFT_LEN);
  typedef logic signed [PFB_WIDTH-1:0] sample_t;
  typedef enum logic {IDLE, READ} phasecomp_state_t;
endpackage

// File: rtl/pp_ram.sv
// pp_ram: simple dual-port ping-pong buffer, {bank, addr} addressing, registered read
module pp_ram #(
  parameter int WIDTH = 16,
  parameter int AW = 6
)(
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic signed [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]           i_raddr,
  output logic signed [WIDTH-1:0] o_rdata
);
  logic signed [WIDTH-1:0] r_mem [2**AW];
  // write when valid, read every cycle through the output register
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/phasecomp.sv
// phasecomp: buffers frames and replays each rotated by the per-frame PFB phase offset
module phasecomp import pfb_pkg::*; #(
  parameter int WIDTH = PFB_WIDTH,
  parameter int FFT_LEN = PFB_FFT_LEN,
  parameter int DEC_FAC = PFB_DEC_FAC
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vin,
  input  logic signed [WIDTH-1:0] din,
  output logic                    vout,
  output logic signed [WIDTH-1:0] dout,
  output logic                    last,
  output logic                    frame_err
);
  localparam int AW = $clog2(FFT_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_LEN - 1);
  localparam logic [AW-1:0] STEP = AW'(DEC_FAC);
  phasecomp_state_t r_state, w_state_nx;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_shift, r_cur_shift, w_rd_off;
  logic r_wr_bank, r_rd_bank, w_rd_bank_nx, w_start;
  logic [1:0] r_full, w_set, w_clr, w_avail;
  logic r_vout, r_last, r_frame_err;
  logic signed [WIDTH-1:0] w_rdata;
  assign w_set = (vin && r_wr_ptr == LAST_IDX) ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = (r_state == READ && r_rd_ptr == LAST_IDX) ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_avail = r_full | w_set;
  assign w_rd_off = r_rd_ptr + r_cur_shift;
  // next state: start from idle on any full bank, chain at end of frame if the other bank is ready
  always_comb begin
    w_state_nx = r_state;
    w_start = 1'b0;
    w_rd_bank_nx = r_rd_bank;
    if (r_state == IDLE) begin
      if (|w_avail) begin
        w_state_nx = READ;
        w_start = 1'b1;
        w_rd_bank_nx = ~w_avail[0];
      end
    end else if (r_rd_ptr == LAST_IDX) begin
      if (w_avail[~r_rd_bank]) begin
        w_start = 1'b1;
        w_rd_bank_nx = ~r_rd_bank;
      end else begin
        w_state_nx = IDLE;
      end
    end
  end
  // pointers, bank flags, shift accumulator and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wr_ptr <= '0;
      r_wr_bank <= 1'b0;
      r_rd_ptr <= '0;
      r_rd_bank <= 1'b0;
      r_full <= 2'b00;
      r_shift <= '0;
      r_cur_shift <= '0;
      r_vout <= 1'b0;
      r_last <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_rd_bank <= w_rd_bank_nx;
      if (vin) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_wr_bank <= r_wr_bank ^ (|w_set);
      r_full <= (r_full & ~w_clr) | w_set;
      r_frame_err <= r_frame_err | (|(w_set & r_full & ~w_clr));
      r_rd_ptr <= w_start ? '0 : r_rd_ptr + AW'(1);
      if (w_start) begin
        r_cur_shift <= r_shift;
        r_shift <= r_shift + STEP;
      end
      r_vout <= r_state == READ;
      r_last <= r_state == READ && r_rd_ptr == LAST_IDX;
    end
  end
  pp_ram #(.WIDTH(WIDTH), .AW(AW + 1)) u_ram (
    .clk(clk),
    .i_we(vin),
    .i_waddr({r_wr_bank, r_wr_ptr}),
    .i_wdata(din),
    .i_raddr({r_rd_bank, w_rd_off}),
    .o_rdata(w_rdata)
  );
  assign vout = r_vout;
  assign dout = r_vout ? w_rdata : '0;
  assign last = r_last;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_phasecomp.sv
// tb_phasecomp: randomized self-checking bench for phasecomp against a frame-level model
module tb_phasecomp;
  import pfb_pkg::*;
  localparam int N = 2**ADDR_W;
  localparam int DEC = PFB_DEC_FAC;
  typedef struct {sample_t d; bit l; int c;} exp_t;
  logic clk, rst, vin, vout, last, frame_err;
  sample_t din, dout;
  int n_tot, n_bad, cyc, k, model_end, start;
  bit mon_on, ev, rv;
  exp_t exp_q[$];
  exp_t e;
  sample_t part[$];

  phasecomp #(.WIDTH(PFB_WIDTH), .FFT_LEN(N), .DEC_FAC(DEC)) dut (
    .clk(clk), .rst(rst), .vin(vin), .din(din),
    .vout(vout), .dout(dout), .last(last), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input sample_t d);
    @(posedge clk);
    #1;
    vin = v;
    din = d;
  endtask

  task automatic drain();
    for (int w = 0; w < 200 && exp_q.size() > 0; w++) drive(1'b0, '0);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  // reference model: frame k leaves as in[(i + k*DEC) mod N], starting 2 cycles after
  // its last input or right after the previous output frame, whichever is later
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      part.delete();
      k = 0;
      model_end = 0;
    end else if (mon_on) begin
      ev = exp_q.size() > 0 && exp_q[0].c == cyc;
      chk("vout", vout, ev);
      if (ev) begin
        e = exp_q.pop_front();
        if (vout) begin
          chk("dout", dout, e.d);
          chk("last", last, e.l);
        end
      end
      chk("ferr", frame_err, 0);
      if (vin) begin
        part.push_back(din);
        if (part.size() == N) begin
          start = (cyc + 2 > model_end + 1) ? cyc + 2 : model_end + 1;
          for (int i = 0; i < N; i++) begin
            e.d = part[(i + k * DEC) % N];
            e.l = (i == N - 1);
            e.c = start + i;
            exp_q.push_back(e);
          end
          model_end = start + N - 1;
          k++;
          part.delete();
        end
      end
    end
  end

  initial begin
    n_tot = 0;
    n_bad = 0;
    rst = 1'b1;
    vin = 1'b0;
    din = '0;
    mon_on = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vout", vout, 0);
    chk("rst_dout", dout, 0);
    chk("rst_last", last, 0);
    chk("rst_ferr", frame_err, 0);
    #1 rst = 1'b1;
    for (int i = 0; i < 8 * N; i++) drive(1'b1, sample_t'(i));
    drive(1'b0, '0);
    drain();
    do_reset();
    for (int i = 0; i < 2 * N; i++) begin
      drive(1'b1, sample_t'(i));
      drive(1'b0, '0);
    end
    drain();
    for (int n = 0; n < 6 * N; ) begin
      rv = $urandom_range(0, 3) != 0;
      drive(rv, sample_t'($urandom));
      if (rv) n++;
    end
    drive(1'b0, '0);
    drain();
    do_reset();
    for (int i = 0; i < 2 * N; i++) drive(1'b1, sample_t'($urandom));
    repeat (10) drive(1'b0, '0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_vout", vout, 0);
    chk("arst_dout", dout, 0);
    chk("arst_last", last, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < N; i++) drive(1'b1, sample_t'($urandom));
    drive(1'b0, '0);
    drain();
    mon_on = 1'b0;
    force dut.r_full = 2'b11;
    for (int i = 0; i < N; i++) drive(1'b1, sample_t'(i));
    repeat (2) drive(1'b0, '0);
    release dut.r_full;
    chk("ovf_set", frame_err, 1);
    repeat (5) drive(1'b0, '0);
    chk("ovf_hold", frame_err, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("ovf_clr", frame_err, 0);
    mon_on = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < N; i++) drive(1'b1, sample_t'(N - i));
    drive(1'b0, '0);
    drain();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/phasecomp.md
Name: phasecomp

Overview:
- Phase-compensation stage directly downstream of the polyphase filter datapath, upstream of the FFT.
- Collects FFT_LEN filtered samples per frame into a ping-pong buffer.
- Reads each frame back circularly rotated by the per-frame oversampled-PFB phase offset (k*DEC_FAC mod FFT_LEN), so the FFT sees a phase-aligned frame.
- Runs 1 sample/cycle, no backpressure.

Parameters:
- WIDTH, 16, sample width (signed two's complement).
- FFT_LEN, 32, frame length; power of 2, >= 4.
- DEC_FAC, 24, decimation factor; 0 < DEC_FAC < FFT_LEN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- vin  in  1  input sample valid.
- din  in  WIDTH  signed input sample from filter datapath sout.
- vout  out  1  output sample valid.
- dout  out  WIDTH  signed rotated sample to FFT.
- last  out  1  high with vout on final sample (index FFT_LEN-1) of each output frame.
- frame_err  out  1  sticky; set if a frame completes while both banks are occupied.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, wr_bank=0, both bank-full flags=0, shift=0, FSM=IDLE.
  - vout=0, dout=0, last=0, frame_err=0.
  - Buffer RAM contents are not reset.
- Write side:
  - On each vin=1: write din to bank[wr_bank][wr_ptr], then wr_ptr++.
  - When wr_ptr==FFT_LEN-1 and vin=1: set full[wr_bank], toggle wr_bank, wr_ptr wraps to 0 (natural wrap).
  - vin=0: no write, no pointer change; gaps inside a frame are allowed.
- Read FSM states: IDLE, READ.
  - IDLE -> READ on the cycle after any full flag is set.
    - Select that bank; rd_ptr=0; latch cur_shift=shift; shift <= (shift+DEC_FAC) mod FFT_LEN.
  - READ:
    - Issue read address (rd_ptr + cur_shift) mod FFT_LEN; rd_ptr++ every cycle.
    - At rd_ptr==FFT_LEN-1: clear full[rd_bank].
    - If the other bank is full (including one set this same cycle), go to READ on it back-to-back and advance shift again. Otherwise go to IDLE.
- RAM read is registered (1 cycle). vout/dout/last are registered outputs.
- Latency: last input sample of a frame at cycle t -> first output sample at t+2.
- Output frame k:
  - dout[i] = input_frame_k[(i + k*DEC_FAC) mod FFT_LEN], i = 0..FFT_LEN-1.
  - Exactly FFT_LEN consecutive vout cycles.
  - k counts from 0 at reset.
- Simultaneous events:
  - Write to bank A while bank B is read is legal.
  - A frame completing on the same cycle a read finishes chains with no gap.
- Overflow:
  - If a frame completes into a bank whose full flag is still set, set frame_err (sticky until reset).
  - The frame is overwritten; the shift sequence is not disturbed.
  - Unreachable at <=1 sample/cycle; retained for integration debug.
- Arithmetic: shift and address sums are $clog2(FFT_LEN) bits wide and wrap naturally, since FFT_LEN is a power of 2.
- Reset mid-frame discards partial and pending frames; the next frame after release is frame 0 with shift 0.

Decomposition:
- Shared package pfb_pkg:
  - sample_t (signed WIDTH).
  - Helper localparam ADDR_W = $clog2(FFT_LEN).
  - Enum phasecomp_state_t {IDLE, READ}.
- One sub-module: pp_ram, a simple dual-port 2*FFT_LEN x WIDTH RAM.
  - Write port: {bank, addr}.
  - Registered read port: {bank, addr}.
  - Inferable as LUTRAM/BRAM.
- phasecomp holds the counters, flags, shift accumulator and FSM.

Test Plan:
- Reset then continuous ramp din=0..31 (frame 0) -> vout first at cycle 33 after the first vin; dout=0..31; last on 31; frame_err=0.
- Frame 1 din=32..63 back-to-back -> dout=56..63,32..55. Frame 2 din=64..95 -> dout=80..95,64..79. Frame 3 -> shift 8. Frame 4 -> shift 0 again.
- Continuous vin for 8 frames -> vout continuous with no gaps after the initial 2-cycle latency; exactly 256 outputs; last every 32nd.
- vin toggled 1/0 every cycle for 2 frames -> output content identical to the continuous case; each frame output as 32 contiguous vout cycles.
- Assert rst=0 asynchronously mid-read of frame 1 -> vout/dout/last drop to 0 immediately. Next full frame after release outputs with shift 0 (unrotated).
- Force an overflow by holding the read FSM via a bench force of full flags -> frame_err=1 and stays 1 until rst.
